uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx.sv | 156 +++++++++++++++
 tb/tb_uart_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle between a byte producer and the UART transmitter.
interface uart_tx_if;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;
    logic       oTx;
    logic       oBusy;

    modport master (
        output iData,
        output iValid,
        input  oReady,
        input  oTx,
        input  oBusy
    );

    modport slave (
        input  iData,
        input  iValid,
        output oReady,
        output oTx,
        output oBusy
    );
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a bit serialiser.
// states: IDLE line high, waiting | START start bit | DATA bits 0..7 LSB first | STOP stop bit
module uart_tx #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int CLK_DIV    = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input logic     iClk,
    input logic     iRstN,
    uart_tx_if.slave bus
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;

    logic             w_push;
    logic             w_pop;
    logic             w_div_zero;
    logic             w_not_full;
    logic             w_not_empty;
    logic [7:0]       w_head;

    assign w_not_full  = (r_count != CNT_FULL);
    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.iValid & w_not_full;
    assign w_div_zero  = (r_div == '0);
    assign w_head      = r_mem[r_rd_ptr];

    // The serialiser takes the head either from idle or at the end of a stop bit.
    always_comb begin
        w_pop = 1'b0;
        if (w_not_empty) begin
            if (r_state == S_IDLE)
                w_pop = 1'b1;
            else if ((r_state == S_STOP) && w_div_zero)
                w_pop = 1'b1;
        end
    end

    assign bus.oReady = w_not_full;
    assign bus.oBusy  = (r_state != S_IDLE) | w_not_empty;
    assign bus.oTx    = r_tx;

    always_ff @(posedge iClk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.iData;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_div   <= DIV_RELOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_div_zero) begin
                        r_div     <= DIV_RELOAD;
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_div_zero) begin
                        r_div   <= DIV_RELOAD;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    // Chaining straight into the next start bit keeps frames gap-free.
                    if (w_div_zero) begin
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_div   <= DIV_RELOAD;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of accepted bytes checked against a mid-bit line decoder.
module tb_uart_tx;

    localparam int CLK_FREQ   = 1000;
    localparam int BAUD       = 100;
    localparam int CLK_DIV    = CLK_FREQ / BAUD;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = CLK_DIV / 2;
    localparam int FRAME      = 10 * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_acc  = 0;

    logic [7:0] sb_q [$];

    uart_tx_if bus ();

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .iClk (clk),
        .iRstN(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line decoder: detects a start bit, samples every bit at its midpoint.
    bit         mon_on  = 1'b0;
    int         mon_t   = 0;
    int         gap     = 0;
    bit         exp_b2b = 1'b0;
    logic [7:0] mon_byte;
    logic [7:0] exp_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_on  = 1'b0;
            exp_b2b = 1'b0;
        end else if (!mon_on) begin
            gap++;
            if (bus.oTx === 1'b0) begin
                if (exp_b2b)
                    chk("b2b_gap", gap, CLK_DIV - HALF);
                exp_b2b = 1'b0;
                mon_on  = 1'b1;
                mon_t   = 0;
            end
        end else begin
            mon_t++;
            if (mon_t >= HALF && ((mon_t - HALF) % CLK_DIV) == 0) begin
                if (mon_t == HALF) begin
                    chk("start_bit", int'(bus.oTx), 0);
                end else if (mon_t < HALF + 9 * CLK_DIV) begin
                    mon_byte = {bus.oTx, mon_byte[7:1]};
                end else begin
                    chk("stop_bit", int'(bus.oTx), 1);
                    chk("frame_expected", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        exp_byte = sb_q.pop_front();
                        chk("rx_byte", int'(mon_byte), int'(exp_byte));
                    end
                    mon_on  = 1'b0;
                    gap     = 0;
                    exp_b2b = (sb_q.size() > 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, output int stalls);
        stalls = 0;
        @(negedge clk);
        bus.iValid = 1'b1;
        while (bus.oReady !== 1'b1 && stalls < 4 * FRAME) begin
            bus.iData = 8'($urandom);
            stalls++;
            @(negedge clk);
        end
        if (bus.oReady !== 1'b1) begin
            chk("accept_timeout", int'(bus.oReady), 1);
            bus.iValid = 1'b0;
            return;
        end
        bus.iData = b;
        @(posedge clk);
        t_acc = cyc;
        sb_q.push_back(b);
    endtask

    task automatic stop_valid();
        @(negedge clk);
        bus.iValid = 1'b0;
        bus.iData  = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((bus.oBusy !== 1'b0 || mon_on) && n < 20 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy", int'(bus.oBusy), 0);
        chk("drain_queue", sb_q.size(), 0);
    endtask

    initial begin
        #(30000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         st;
        int         k0;
        int         exp_tx;
        int         idx;
        logic [9:0] fr;
        logic [7:0] b2b [6];
        logic [7:0] v;

        bus.iValid = 1'b0;
        bus.iData  = 8'h00;
        rst_n      = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(bus.oTx), 1);
        chk("rst_ready", int'(bus.oReady), 1);
        chk("rst_busy", int'(bus.oBusy), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_tx", int'(bus.oTx), 1);
            chk("idle_ready", int'(bus.oReady), 1);
            chk("idle_busy", int'(bus.oBusy), 0);
        end

        // Single byte, cycle-exact line and busy profile
        send(8'h55, st);
        chk("single_stall", st, 0);
        fr = {1'b1, 8'h55, 1'b0};
        stop_valid();
        for (int j = 0; j <= FRAME + 1; j++) begin
            if (j == 0) begin
                exp_tx = 1;
            end else begin
                idx    = (j - 1) / CLK_DIV;
                exp_tx = (idx < 10) ? int'(fr[idx]) : 1;
            end
            chk("single_tx", int'(bus.oTx), exp_tx);
            chk("single_busy", int'(bus.oBusy), (j <= FRAME) ? 1 : 0);
            chk("single_ready", int'(bus.oReady), 1);
            @(negedge clk);
        end
        wait_drain();

        // Back-to-back, FIFO fill and backpressure
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'hA5;
        b2b[3] = 8'h3C; b2b[4] = 8'h81; b2b[5] = 8'h5A;
        k0 = 0;
        for (int i = 0; i < 6; i++) begin
            send(b2b[i], st);
            if (i == 0)
                k0 = t_acc;
            if (i < 5) begin
                chk("b2b_no_stall", st, 0);
            end else begin
                chk("full_stall", st, FRAME - 3);
                chk("full_accept_edge", t_acc - k0, FRAME + 2);
            end
        end
        stop_valid();
        wait_drain();

        // Reset mid-frame, during data bit 3 of 0x0F with two bytes queued
        send(8'h0F, st);
        send(8'h11, st);
        send(8'h22, st);
        stop_valid();
        repeat (43) @(negedge clk);
        chk("pre_rst_bit3", int'(bus.oTx), 1);
        chk("pre_rst_busy", int'(bus.oBusy), 1);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("midrst_tx", int'(bus.oTx), 1);
        chk("midrst_busy", int'(bus.oBusy), 0);
        chk("midrst_ready", int'(bus.oReady), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 15 * CLK_DIV; i++) begin
            @(negedge clk);
            chk("postrst_tx", int'(bus.oTx), 1);
            chk("postrst_busy", int'(bus.oBusy), 0);
        end

        // Push on the exact edge the STOP state pops; pointers wrap three times
        send(8'h13, st);
        send(8'h30, st);
        for (int i = 2; i < 3 * FIFO_DEPTH; i++) begin
            v = 8'(i * 29 + 19);
            stop_valid();
            repeat (FRAME - 2) @(negedge clk);
            chk("pp_busy", int'(bus.oBusy), 1);
            send(v, st);
            chk("pp_no_stall", st, 0);
        end
        stop_valid();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
